// File: rtl/usb_tx_pkt_ctrl.sv
// usb_tx_pkt_ctrl: USB TX packet controller; define TX_CTRL_STATS_EN to add pkt_count/err_count
module usb_tx_pkt_ctrl #(
  parameter int BUF_DEPTH      = 64,
  parameter int OCC_W          = $clog2(BUF_DEPTH+1),
  parameter int MAX_PKT_BYTES  = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [2:0]       tx_packet,
  input  logic             end_packet,
  input  logic             byte_req,
  input  logic [OCC_W-1:0] buffer_occupancy,
  output logic             tx_transfer_active,
  output logic             begin_packet,
  output logic             get_tx_packet_data,
  output logic [2:0]       tx_pid_type,
  output logic [OCC_W-1:0] byte_count,
  output logic             tx_done,
  output logic             tx_error,
`ifdef TX_CTRL_STATS_EN
  output logic [15:0]      pkt_count,
  output logic [7:0]       err_count,
`endif
  output logic [2:0]       tx_err_code
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);
  typedef enum logic [2:0] {S_IDLE, S_BEGIN, S_SEND_DATA, S_SEND_HS, S_DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] prev_q, pid_q, pid_d, code_q, code_d, err_d;
  logic [OCC_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic err_q, req_new, is_data, active, sending, underrun, timeout;
  assign req_new  = tx_packet != 3'd0 && tx_packet != prev_q;
  assign is_data  = tx_packet == 3'd1 || tx_packet == 3'd2;
  assign sending  = state_q == S_SEND_DATA || state_q == S_SEND_HS;
  assign active   = state_q == S_BEGIN || sending || state_q == S_DONE;
  assign underrun = state_q == S_SEND_DATA && byte_req && cnt_q != '0 && buffer_occupancy == '0;
  assign timeout  = sending && wd_q == WD_W'(TIMEOUT_CYCLES-1);
  assign tx_transfer_active = active;
  assign begin_packet       = state_q == S_BEGIN;
  assign tx_done            = state_q == S_DONE;
  assign get_tx_packet_data = state_q == S_SEND_DATA && byte_req && cnt_q != '0 && buffer_occupancy != '0;
  assign tx_pid_type        = pid_q;
  assign byte_count         = cnt_q;
  assign tx_error           = err_q;
  assign tx_err_code        = code_q;
  // next state, request checks, payload counting, watchdog and error selection (lowest code wins)
  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    err_d   = 3'd0;
    case (state_q)
      S_IDLE: if (req_new) begin
        if (tx_packet > 3'd5) err_d = 3'd1;
        else if (is_data && buffer_occupancy == '0) err_d = 3'd2;
        else if (is_data && buffer_occupancy > OCC_W'(MAX_PKT_BYTES)) err_d = 3'd3;
        else begin
          state_d = S_BEGIN;
          pid_d   = tx_packet;
          cnt_d   = is_data ? buffer_occupancy : '0;
          wd_d    = '0;
        end
      end
      S_BEGIN: begin
        state_d = pid_q <= 3'd2 ? S_SEND_DATA : S_SEND_HS;
        wd_d    = '0;
      end
      S_SEND_DATA, S_SEND_HS: begin
        wd_d = wd_q + 1'b1;
        if (get_tx_packet_data) cnt_d = cnt_q - 1'b1;
        if (end_packet) state_d = S_DONE;
        else if (underrun || timeout) begin
          state_d = S_IDLE;
          err_d   = underrun ? 3'd5 : 3'd6;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (active && req_new) err_d = 3'd4;
    code_d = err_d != 3'd0 ? err_d : (state_q == S_IDLE && state_d == S_BEGIN) ? 3'd0 : code_q;
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      prev_q  <= 3'd0;
      pid_q   <= 3'd0;
      cnt_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      prev_q  <= tx_packet;
      pid_q   <= pid_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      err_q   <= err_d != 3'd0;
      code_q  <= code_d;
    end
  end
`ifdef TX_CTRL_STATS_EN
  logic [15:0] pkt_q, pkt_d;
  logic [7:0] errc_q, errc_d;
  assign pkt_count = pkt_q;
  assign err_count = errc_q;
  // saturating completion and error counters
  always_comb begin
    pkt_d  = (tx_done && ~&pkt_q) ? pkt_q + 16'd1 : pkt_q;
    errc_d = (err_q && ~&errc_q) ? errc_q + 8'd1 : errc_q;
  end
  // counter registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pkt_q  <= '0;
      errc_q <= '0;
    end else begin
      pkt_q  <= pkt_d;
      errc_q <= errc_d;
    end
  end
`endif
endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// tb_usb_tx_pkt_ctrl: directed self-checking bench for usb_tx_pkt_ctrl
module tb_usb_tx_pkt_ctrl;
  logic clk, n_rst, end_packet, byte_req;
  logic [2:0] tx_packet;
  logic [6:0] occ;
  logic active, begin_packet, get, tx_done, tx_error;
  logic [2:0] pid, code;
  logic [6:0] bc;
`ifdef TX_CTRL_STATS_EN
  logic [15:0] pkt_count;
  logic [7:0] err_count;
`endif
  int checks = 0;
  int errors = 0;
  int pops, begs, errs;
  logic p;
  usb_tx_pkt_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .n_rst(n_rst), .tx_packet(tx_packet), .end_packet(end_packet),
    .byte_req(byte_req), .buffer_occupancy(occ), .tx_transfer_active(active),
    .begin_packet(begin_packet), .get_tx_packet_data(get), .tx_pid_type(pid),
    .byte_count(bc), .tx_done(tx_done), .tx_error(tx_error),
`ifdef TX_CTRL_STATS_EN
    .pkt_count(pkt_count), .err_count(err_count),
`endif
    .tx_err_code(code)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    n_rst = 1'b0; tx_packet = 3'd0; end_packet = 1'b0; byte_req = 1'b0; occ = 7'd0;
    #12;
    chk("rst_active", active, 0); chk("rst_begin", begin_packet, 0); chk("rst_get", get, 0);
    chk("rst_pid", pid, 0); chk("rst_bc", bc, 0); chk("rst_done", tx_done, 0);
    chk("rst_err", tx_error, 0); chk("rst_code", code, 0);
    n_rst = 1'b1;
    tick();
    // DATA0, 3 bytes, byte_req every 4 cycles
    tx_packet = 3'd1; occ = 7'd3;
    tick();
    chk("d0_begin", begin_packet, 1); chk("d0_active", active, 1);
    chk("d0_pid", pid, 1); chk("d0_bc", bc, 3);
    tick();
    chk("d0_begin_once", begin_packet, 0);
    pops = 0; errs = 0;
    for (int i = 0; i < 9; i++) begin
      byte_req = (i % 4) == 0;
      #1;
      p = get;
      if (p) pops++;
      tick();
      if (p) occ = occ - 7'd1;
      if (tx_error) errs++;
    end
    byte_req = 1'b0;
    chk("d0_pops", pops, 3); chk("d0_bc_zero", bc, 0);
    end_packet = 1'b1;
    tick();
    end_packet = 1'b0;
    chk("d0_done", tx_done, 1); chk("d0_done_active", active, 1);
    tick();
    chk("d0_done_pulse", tx_done, 0); chk("d0_idle", active, 0);
    chk("d0_no_err", errs, 0); chk("d0_err_now", tx_error, 0);
    // ACK handshake, byte_req held high must not pop
    tx_packet = 3'd3;
    tick();
    chk("ack_begin", begin_packet, 1); chk("ack_pid", pid, 3); chk("ack_bc", bc, 0);
    tick();
    pops = 0; begs = 0; byte_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (get) pops++;
      if (begin_packet) begs++;
      tick();
    end
    byte_req = 1'b0;
    chk("ack_pops", pops, 0); chk("ack_begs", begs, 0);
    end_packet = 1'b1;
    tick();
    end_packet = 1'b0;
    chk("ack_done", tx_done, 1); chk("ack_pid_hold", pid, 3);
    tick();
    // DATA1 with empty buffer
    tx_packet = 3'd2; occ = 7'd0;
    tick();
    chk("empty_err", tx_error, 1); chk("empty_code", code, 2);
    chk("empty_idle", active, 0); chk("empty_begin", begin_packet, 0);
    tick();
    chk("empty_pulse", tx_error, 0); chk("empty_code_hold", code, 2); chk("empty_still_idle", active, 0);
    // DATA1 oversize
    tx_packet = 3'd0;
    tick();
    tx_packet = 3'd2; occ = 7'd65;
    tick();
    chk("over_err", tx_error, 1); chk("over_code", code, 3); chk("over_begin", begin_packet, 0);
    tick();
    chk("over_begin2", begin_packet, 0);
    // invalid code
    tx_packet = 3'd7;
    tick();
    chk("inv_err", tx_error, 1); chk("inv_code", code, 1);
    // NAK, then change to STALL mid-transfer
    tx_packet = 3'd4;
    tick();
    chk("nak_begin", begin_packet, 1); chk("nak_code_clr", code, 0);
    tick();
    tx_packet = 3'd5;
    tick();
    chk("chg_err", tx_error, 1); chk("chg_code", code, 4);
    chk("chg_active", active, 1); chk("chg_pid", pid, 4);
    tick();
    end_packet = 1'b1;
    tick();
    end_packet = 1'b0;
    chk("chg_done", tx_done, 1);
    tick();
    // DATA0, occupancy 2, FIFO drained before second byte_req
    tx_packet = 3'd1; occ = 7'd2;
    tick();
    tick();
    byte_req = 1'b1;
    #1;
    chk("ur_pop1", get, 1);
    tick();
    byte_req = 1'b0; occ = 7'd0;
    tick();
    byte_req = 1'b1;
    #1;
    chk("ur_no_pop", get, 0);
    tick();
    byte_req = 1'b0;
    chk("ur_err", tx_error, 1); chk("ur_code", code, 5); chk("ur_active", active, 0);
    chk("ur_done", tx_done, 0); chk("ur_bc_resid", bc, 1);
    tick();
    chk("ur_no_done", tx_done, 0);
    // ACK without end_packet, watchdog of 16 send cycles
    tx_packet = 3'd3;
    tick();
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("to_still_active", active, 1); chk("to_no_err_yet", tx_error, 0);
    tick();
    chk("to_err", tx_error, 1); chk("to_code", code, 6);
    chk("to_active", active, 0); chk("to_done", tx_done, 0);
`ifdef TX_CTRL_STATS_EN
    tick();
    chk("st_pkt", pkt_count, 3); chk("st_err", err_count, 6);
`endif
    // reset in SEND_DATA with 5 bytes pending
    tx_packet = 3'd0;
    tick();
    tx_packet = 3'd1; occ = 7'd5;
    tick();
    tick();
    chk("rs_bc", bc, 5); chk("rs_active", active, 1);
    byte_req = 1'b1;
    n_rst = 1'b0;
    #1;
    chk("rs_active0", active, 0); chk("rs_get0", get, 0); chk("rs_begin0", begin_packet, 0);
    chk("rs_pid0", pid, 0); chk("rs_bc0", bc, 0); chk("rs_done0", tx_done, 0);
    chk("rs_err0", tx_error, 0); chk("rs_code0", code, 0);
`ifdef TX_CTRL_STATS_EN
    chk("rs_pkt0", pkt_count, 0); chk("rs_errc0", err_count, 0);
`endif
    byte_req = 1'b0;
    #2;
    n_rst = 1'b1;
    tick();
    chk("rs_restart_begin", begin_packet, 1); chk("rs_restart_pid", pid, 1); chk("rs_restart_bc", bc, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/usb_tx_pkt_ctrl.md
Name: usb_tx_pkt_ctrl

Overview:
Parametrised USB TX packet controller between the endpoint/protocol layer and the TX encoder. It accepts a packet request (data or handshake PID) and drives the encoder start and data-fetch handshakes. It counts payload bytes against buffer occupancy and reports coded errors for the cases below:
- invalid or illegal requests
- buffer underrun
- encoder timeout

Parameters:
BUF_DEPTH, 64, TX FIFO depth in bytes.
OCC_W, $clog2(BUF_DEPTH+1), width of buffer_occupancy.
MAX_PKT_BYTES, 64, largest legal data payload; must be <= BUF_DEPTH.
TIMEOUT_CYCLES, 4096, cycles allowed in a send state before abort.

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
tx_packet  in  3  request code: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6-7 invalid
end_packet  in  1  encoder pulse: EOP finished
byte_req  in  1  encoder pulse: ready for next payload byte
buffer_occupancy  in  OCC_W  bytes currently in TX FIFO
tx_transfer_active  out  1  high from BEGIN through DONE
begin_packet  out  1  one-cycle start strobe to encoder
get_tx_packet_data  out  1  FIFO pop strobe
tx_pid_type  out  3  latched code of the packet in flight
byte_count  out  OCC_W  payload bytes remaining
tx_done  out  1  one-cycle successful-completion pulse
tx_error  out  1  one-cycle error pulse
tx_err_code  out  3  0 none, 1 invalid code, 2 empty buffer, 3 oversize, 4 request change while active, 5 underrun, 6 timeout

Behaviour:
- Reset: state IDLE. All outputs are 0. prev_tx_packet, byte counter and watchdog are 0.
- prev_tx_packet is registered every cycle.
- req_new = (tx_packet != 0) && (tx_packet != prev_tx_packet).
- Only req_new starts a packet; a held level never retriggers.
- IDLE, req_new, checked in this priority order:
  - code 6/7 -> error 1
  - DATA with occupancy == 0 -> error 2
  - DATA with occupancy > MAX_PKT_BYTES -> error 3
  - On any of these errors, stay in IDLE.
  - Otherwise go to BEGIN. Latch tx_pid_type, load byte_count = occupancy (DATA) or 0 (handshake), clear tx_err_code to 0.
- BEGIN (exactly 1 cycle): begin_packet = 1, tx_transfer_active = 1. Next state is SEND_DATA for codes 1-2, SEND_HS for codes 3-5.
- SEND_DATA:
  - get_tx_packet_data = byte_req && byte_count != 0 && buffer_occupancy != 0, combinational in the same cycle; byte_count decrements on the same edge.
  - byte_req && byte_count != 0 && buffer_occupancy == 0 -> error 5, abort to IDLE.
  - byte_req with byte_count == 0 is ignored (encoder is sending CRC).
- SEND_HS: no pops; waits for end_packet.
- SEND_DATA/SEND_HS: end_packet -> DONE. end_packet has priority over a same-cycle underrun or timeout.
- DONE (1 cycle): tx_done = 1, tx_transfer_active = 1, then IDLE.
- Watchdog:
  - Clears on entry to BEGIN and increments in SEND_DATA/SEND_HS.
  - When the count reaches TIMEOUT_CYCLES-1 with no end_packet -> error 6, abort to IDLE.
- Any req_new while tx_transfer_active -> error 4. The request is ignored and the transfer continues unaffected.
- Error reporting:
  - Errors are registered: tx_error pulses on the cycle after detection, and tx_err_code updates on that same cycle.
  - tx_err_code holds until the next accepted request.
  - Same-cycle errors: lowest non-zero code wins.
- Abort: tx_transfer_active drops the cycle after detection. tx_done is not asserted. byte_count holds its residual value until the next accept.
- Latency: req_new at cycle N gives begin_packet at N+1 and first possible pop at N+2.
- No state other than IDLE is reachable from an undefined encoding; a default case maps to IDLE.

Optional Feature:
TX_CTRL_STATS_EN:
- Defined: adds outputs pkt_count[15:0], incremented on each tx_done, and err_count[7:0], incremented on each tx_error. Both saturate at all-ones and reset to 0.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- DATA0 request, occupancy = 3, byte_req every 4 cycles, end_packet after the third pop -> begin_packet at N+1, exactly 3 get_tx_packet_data pulses, byte_count 3→0, one tx_done, tx_error never.
- ACK request, end_packet 10 cycles later -> begin_packet once, no pops, tx_done, tx_pid_type = 3.
- Requests with occupancy errors:
  - DATA1 with occupancy = 0 -> tx_error pulse, code 2, state stays IDLE.
  - DATA1 with occupancy = 65 -> code 3, no begin_packet.
- tx_packet = 7 -> code 1. NAK→STALL change mid-transfer -> code 4, transfer completes with tx_done.
- Underrun and timeout aborts:
  - DATA0 with occupancy = 2, FIFO drained externally before the second byte_req -> code 5, tx_transfer_active low the next cycle, no tx_done.
  - With TIMEOUT_CYCLES = 16, no end_packet -> code 6 after 16 send cycles.
- Assert n_rst in SEND_DATA with byte_count = 5 -> all outputs 0 immediately. After release, a held tx_packet = 1 starts a new packet (prev cleared). With TX_CTRL_STATS_EN, pkt_count and err_count read 0.
